// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipe_stage_reg slice.
//   DATA_W_DEF / OP_W_DEF : default payload and opcode widths
//   NOP_OP                : opcode shown downstream when the stage is empty
//   skid_state_e          : occupancy encoding used when PIPE_STAGE_SKID_EN is defined
package pipe_pkg;

    localparam int         DATA_W_DEF = 20;
    localparam int         OP_W_DEF   = 4;
    localparam logic [3:0] NOP_OP     = 4'h0;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one opcode+payload holding register with a valid bit.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   flush                drop the held beat (payload kept, opcode -> BUBBLE_OP)
//   load                 capture d_opcode/d_data, mark valid
//   unload               drop the held beat when nothing is loaded
//   d_opcode, d_data     incoming beat
//   q_valid, q_opcode, q_data  held beat; q_opcode is BUBBLE_OP when q_valid=0
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                OP_W      = OP_W_DEF,
    parameter logic [OP_W-1:0]   BUBBLE_OP = OP_W'(NOP_OP)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              unload,
    input  logic [OP_W-1:0]   d_opcode,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [OP_W-1:0]   q_opcode,
    output logic [DATA_W-1:0] q_data
);

    // The opcode is rewritten to the bubble value whenever the slot empties,
    // so the downstream opcode comes straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_valid  <= 1'b0;
            q_opcode <= BUBBLE_OP;
            q_data   <= '0;
        end else if (flush) begin
            q_valid  <= 1'b0;
            q_opcode <= BUBBLE_OP;
        end else if (load) begin
            q_valid  <= 1'b1;
            q_opcode <= d_opcode;
            q_data   <= d_data;
        end else if (unload) begin
            q_valid  <= 1'b0;
            q_opcode <= BUBBLE_OP;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// stall back-pressure, synchronous flush and bubble insertion.
// Configuration macro PIPE_STAGE_SKID_EN:
//   undefined - single register, in_ready combinational from out_ready
//   defined   - 2-entry skid buffer, in_ready from a flop
// Ports:
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   flush                           squash stage contents
//   in_valid, in_ready              upstream handshake
//   in_opcode, in_data              upstream beat
//   out_valid, out_ready            downstream handshake
//   out_opcode, out_data            registered beat; out_opcode=BUBBLE_OP when empty
//
// Skid FSM (PIPE_STAGE_SKID_EN):
//   state      | meaning
//   SKID_EMPTY | no beat held
//   SKID_ONE   | beat in main register only
//   SKID_TWO   | main register and skid slot both full, upstream stalled
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W    = DATA_W_DEF,
    parameter int              OP_W      = OP_W_DEF,
    parameter logic [OP_W-1:0] BUBBLE_OP = OP_W'(NOP_OP)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_opcode,
    output logic [DATA_W-1:0] out_data
);

    logic              accept;
    logic              emit;
    logic              main_load;
    logic              main_unload;
    logic [OP_W-1:0]   main_d_opcode;
    logic [DATA_W-1:0] main_d_data;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

    skid_state_e       state_q;
    skid_state_e       state_d;
    logic              rdy_q;
    logic              skid_load;
    logic              skid_unload;
    logic              skid_valid;
    logic [OP_W-1:0]   skid_opcode;
    logic [DATA_W-1:0] skid_data;
    logic              main_from_skid;

    // rdy_q looks one state ahead so in_ready never depends on out_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SKID_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != SKID_TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: if (accept) state_d = SKID_ONE;
                SKID_ONE: begin
                    if (accept && !emit)      state_d = SKID_TWO;
                    else if (emit && !accept) state_d = SKID_EMPTY;
                end
                SKID_TWO:   if (emit) state_d = SKID_ONE;
                default:    state_d = SKID_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_load      = 1'b0;
        main_unload    = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_unload    = 1'b0;
        case (state_q)
            SKID_EMPTY: main_load = accept;
            SKID_ONE: begin
                main_load   = accept & emit;
                main_unload = emit & ~accept;
                skid_load   = accept & ~emit;
            end
            SKID_TWO: begin
                main_from_skid = 1'b1;
                main_load      = emit;
                skid_unload    = emit & skid_valid;
            end
            default: ;
        endcase
    end

    assign in_ready      = rdy_q & ~flush;
    assign main_d_opcode = main_from_skid ? skid_opcode : in_opcode;
    assign main_d_data   = main_from_skid ? skid_data   : in_data;

    pipe_skid_slot #(
        .DATA_W    (DATA_W),
        .OP_W      (OP_W),
        .BUBBLE_OP (BUBBLE_OP)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .load     (skid_load),
        .unload   (skid_unload),
        .d_opcode (in_opcode),
        .d_data   (in_data),
        .q_valid  (skid_valid),
        .q_opcode (skid_opcode),
        .q_data   (skid_data)
    );

`else

    assign in_ready      = (~out_valid | out_ready) & ~flush;
    assign main_load     = accept;
    assign main_unload   = emit;
    assign main_d_opcode = in_opcode;
    assign main_d_data   = in_data;

`endif

    pipe_skid_slot #(
        .DATA_W    (DATA_W),
        .OP_W      (OP_W),
        .BUBBLE_OP (BUBBLE_OP)
    ) u_main (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .load     (main_load),
        .unload   (main_unload),
        .d_opcode (main_d_opcode),
        .d_data   (main_d_data),
        .q_valid  (out_valid),
        .q_opcode (out_opcode),
        .q_data   (out_data)
    );

endmodule
